// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetcher with a DEPTH-entry prefetch buffer,
// one outstanding memory request, redirect flush/drain and misaligned-fetch fault.
module fetch_unit #(
    parameter int DEPTH  = 2,
    parameter int INC_BY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        pc_aligned_i,
    output logic        pc_en_o,
    input  logic        redirect_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i,
    output logic        fault_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, FAULT} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_count, w_count_nxt;
    logic [AW-1:0] r_wptr, r_rptr;
    logic [63:0]   r_buf [DEPTH];
    logic [31:0]   r_addr;
    logic          w_push, w_pop;

    assign mem_req_o    = r_state == REQ;
    assign mem_addr_o   = r_addr;
    assign pc_en_o      = (r_state == REQ) & mem_gnt_i & ~redirect_i;
    assign fault_o      = r_state == FAULT;
    assign inst_valid_o = r_count != '0;
    assign inst_o       = r_buf[r_rptr][63:32];
    assign inst_pc_o    = r_buf[r_rptr][31:0];
    assign w_push       = (r_state == WAIT) & mem_rvalid_i & ~redirect_i;
    assign w_pop        = inst_valid_o & inst_ready_i;
    assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);

    // In WAIT the outstanding request retires this cycle, so credit uses the post-push count
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (!redirect_i && r_count < CW'(DEPTH)) w_next = pc_aligned_i ? REQ : FAULT;
            REQ:   w_next = redirect_i ? IDLE : (mem_gnt_i ? WAIT : REQ);
            WAIT:  if (redirect_i) w_next = mem_rvalid_i ? IDLE : DRAIN;
                   else if (mem_rvalid_i) w_next = (w_count_nxt < CW'(DEPTH)) ? (pc_aligned_i ? REQ : FAULT) : IDLE;
            DRAIN: if (!redirect_i && mem_rvalid_i) w_next = IDLE;
            FAULT: if (redirect_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == REQ && r_state != REQ) r_addr <= pc_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
        end else if (redirect_i) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) begin
                r_buf[r_wptr] <= {mem_rdata_i, r_addr};
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i) !(w_push && !w_pop && r_count == CW'(DEPTH)));
    assert property (@(posedge clk_i) disable iff (rst_i) pc_en_o |-> (INC_BY > 0 && (DEPTH == 2 || DEPTH == 4)));
endmodule
